dev_fifo_port: RTL and testbench

Parametrised keyboard/screen device port, successor to the single-byte kb/scr driver. Each direction has a DEPTH-entry FIFO and an 8-bit CSR with the existing bit layout: 4 ena, 3 of, 2 dba, 1 io, 0 ie. The RX channel (kb) takes bytes from an input device, and the TX channel (scr) drives an output device. The CPU side is a registered read/write port with a combined interrupt output.

---
 rtl/dev_fifo_port.sv | 196 +++++++++++++++++++
 tb/tb_dev_fifo_port.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dev_fifo_port.sv
// Keyboard/screen device port: a DEPTH-entry RX and TX FIFO per direction, each with an
// 8-bit CSR (4 ena, 3 of, 2 dba, 1 io, 0 ie), a registered CPU port and a combined irq.
module dev_fifo_port #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    input  logic [1:0]    cpu_addr,
    input  logic          cpu_wr,
    input  logic          cpu_rd,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          irq
);

    typedef logic [AW:0]   ptr_t;
    typedef logic [DW-1:0] word_t;

    typedef enum logic [1:0] {
        ADDR_KB_DATA  = 2'b00,
        ADDR_KB_CSR   = 2'b01,
        ADDR_SCR_DATA = 2'b10,
        ADDR_SCR_CSR  = 2'b11
    } addr_e;

    // FIFO storage and pointers
    word_t rx_mem_q [DEPTH];
    word_t rx_mem_d [DEPTH];
    word_t tx_mem_q [DEPTH];
    word_t tx_mem_d [DEPTH];
    ptr_t  rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    ptr_t  tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;

    // CSR state bits
    logic  kb_ena_q, kb_ena_d, kb_ie_q, kb_ie_d, kb_of_q, kb_of_d;
    logic  scr_ena_q, scr_ena_d, scr_ie_q, scr_ie_d, scr_of_q, scr_of_d;

    word_t cpu_rdata_q, cpu_rdata_d;
    logic  irq_q, irq_d;

    // Status and strobes
    logic  rx_empty, rx_full, tx_empty, tx_full;
    logic  rx_pop, rx_push_req, rx_push, rx_ovf;
    logic  tx_pop, tx_push_req, tx_push, tx_ovf;
    logic  wr_kb_csr, wr_scr_csr;
    logic  wbit_ena, wbit_of, wbit_ie;
    logic [7:0] kb_csr, scr_csr;
    addr_e addr;

    always_comb begin
        addr     = addr_e'(cpu_addr);

        rx_empty = (rx_wr_q == rx_rd_q);
        rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
        tx_empty = (tx_wr_q == tx_rd_q);
        tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);

        out_valid = scr_ena_q && !tx_empty;
        out_data  = tx_empty ? '0 : tx_mem_q[tx_rd_q[AW-1:0]];

        // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
        rx_pop      = cpu_rd && (addr == ADDR_KB_DATA) && !rx_empty;
        rx_push_req = in_valid && kb_ena_q;
        rx_push     = rx_push_req && (!rx_full || rx_pop);
        rx_ovf      = rx_push_req && rx_full && !rx_pop;

        tx_pop      = out_valid && out_ready;
        tx_push_req = cpu_wr && (addr == ADDR_SCR_DATA) && scr_ena_q;
        tx_push     = tx_push_req && (!tx_full || tx_pop);
        tx_ovf      = tx_push_req && tx_full && !tx_pop;

        wr_kb_csr  = cpu_wr && (addr == ADDR_KB_CSR);
        wr_scr_csr = cpu_wr && (addr == ADDR_SCR_CSR);
        wbit_ena   = |(8'(cpu_wdata) & 8'h10);
        wbit_of    = |(8'(cpu_wdata) & 8'h08);
        wbit_ie    = |(8'(cpu_wdata) & 8'h01);

        kb_csr  = {3'b000, kb_ena_q,  kb_of_q,  !rx_empty, 1'b0, kb_ie_q};
        scr_csr = {3'b000, scr_ena_q, scr_of_q, !tx_full,  1'b1, scr_ie_q};
    end

    always_comb begin
        rx_mem_d = rx_mem_q;
        rx_wr_d  = rx_wr_q;
        rx_rd_d  = rx_rd_q;
        if (rx_push) begin
            rx_mem_d[rx_wr_q[AW-1:0]] = in_data;
            rx_wr_d = rx_wr_q + 1'b1;
        end
        if (rx_pop) begin
            rx_rd_d = rx_rd_q + 1'b1;
        end
    end

    always_comb begin
        tx_mem_d = tx_mem_q;
        tx_wr_d  = tx_wr_q;
        tx_rd_d  = tx_rd_q;
        if (tx_push) begin
            tx_mem_d[tx_wr_q[AW-1:0]] = cpu_wdata;
            tx_wr_d = tx_wr_q + 1'b1;
        end
        if (tx_pop) begin
            tx_rd_d = tx_rd_q + 1'b1;
        end
    end

    // Overflow set is applied after the write-1-to-clear so a coincident overflow wins.
    always_comb begin
        kb_ena_d  = kb_ena_q;
        kb_ie_d   = kb_ie_q;
        kb_of_d   = kb_of_q;
        scr_ena_d = scr_ena_q;
        scr_ie_d  = scr_ie_q;
        scr_of_d  = scr_of_q;
        if (wr_kb_csr) begin
            kb_ena_d = wbit_ena;
            kb_ie_d  = wbit_ie;
            if (wbit_of) begin
                kb_of_d = 1'b0;
            end
        end
        if (wr_scr_csr) begin
            scr_ena_d = wbit_ena;
            scr_ie_d  = wbit_ie;
            if (wbit_of) begin
                scr_of_d = 1'b0;
            end
        end
        if (rx_ovf) begin
            kb_of_d = 1'b1;
        end
        if (tx_ovf) begin
            scr_of_d = 1'b1;
        end
    end

    always_comb begin
        cpu_rdata_d = cpu_rdata_q;
        if (cpu_rd) begin
            unique case (addr)
                ADDR_KB_DATA:  cpu_rdata_d = rx_empty ? '0 : rx_mem_q[rx_rd_q[AW-1:0]];
                ADDR_KB_CSR:   cpu_rdata_d = DW'(kb_csr);
                ADDR_SCR_DATA: cpu_rdata_d = '0;
                ADDR_SCR_CSR:  cpu_rdata_d = DW'(scr_csr);
                default:       cpu_rdata_d = '0;
            endcase
        end
        irq_d = (kb_ie_q && !rx_empty) || (scr_ie_q && !tx_full);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_mem_q    <= '{default: '0};
            tx_mem_q    <= '{default: '0};
            rx_wr_q     <= '0;
            rx_rd_q     <= '0;
            tx_wr_q     <= '0;
            tx_rd_q     <= '0;
            kb_ena_q    <= 1'b0;
            kb_ie_q     <= 1'b0;
            kb_of_q     <= 1'b0;
            scr_ena_q   <= 1'b0;
            scr_ie_q    <= 1'b0;
            scr_of_q    <= 1'b0;
            cpu_rdata_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            rx_mem_q    <= rx_mem_d;
            tx_mem_q    <= tx_mem_d;
            rx_wr_q     <= rx_wr_d;
            rx_rd_q     <= rx_rd_d;
            tx_wr_q     <= tx_wr_d;
            tx_rd_q     <= tx_rd_d;
            kb_ena_q    <= kb_ena_d;
            kb_ie_q     <= kb_ie_d;
            kb_of_q     <= kb_of_d;
            scr_ena_q   <= scr_ena_d;
            scr_ie_q    <= scr_ie_d;
            scr_of_q    <= scr_of_d;
            cpu_rdata_q <= cpu_rdata_d;
            irq_q       <= irq_d;
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_dev_fifo_port.sv
// Self-checking bench for dev_fifo_port: directed scenarios plus a randomized run,
// all compared against a queue-based reference model of the port.
module tb_dev_fifo_port;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic [1:0]    cpu_addr = '0;
    logic          cpu_wr = 1'b0;
    logic          cpu_rd = 1'b0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [DW-1:0] cpu_rdata;
    logic          irq;

    int checks = 0;
    int errors = 0;

    dev_fifo_port #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .cpu_addr(cpu_addr), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: byte queues plus CSR flags, advanced once per clock edge.
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    bit m_kb_ena, m_kb_ie, m_kb_of, m_scr_ena, m_scr_ie, m_scr_of;
    logic [7:0] m_rdata = '0;
    bit m_irq;

    task automatic model_edge();
        int rn, tn;
        bit rx_pop, tx_pop, rx_ovf, tx_ovf, irq_next;
        logic [7:0] kcsr, scsr;
        if (rst) begin
            rxq.delete(); txq.delete();
            m_kb_ena = 0; m_kb_ie = 0; m_kb_of = 0;
            m_scr_ena = 0; m_scr_ie = 0; m_scr_of = 0;
            m_rdata = '0; m_irq = 0;
            return;
        end
        rn = rxq.size();
        tn = txq.size();
        kcsr = {3'b000, m_kb_ena, m_kb_of, rn > 0, 1'b0, m_kb_ie};
        scsr = {3'b000, m_scr_ena, m_scr_of, tn < DEPTH, 1'b1, m_scr_ie};
        irq_next = (m_kb_ie && rn > 0) || (m_scr_ie && tn < DEPTH);
        rx_pop = cpu_rd && cpu_addr == 2'd0 && rn > 0;
        tx_pop = m_scr_ena && tn > 0 && out_ready;
        if (cpu_rd) begin
            case (cpu_addr)
                2'd0: m_rdata = rx_pop ? rxq[0] : 8'h00;
                2'd1: m_rdata = kcsr;
                2'd2: m_rdata = 8'h00;
                default: m_rdata = scsr;
            endcase
        end
        if (rx_pop) void'(rxq.pop_front());
        if (tx_pop) void'(txq.pop_front());
        rx_ovf = 0;
        tx_ovf = 0;
        if (in_valid && m_kb_ena) begin
            if (rxq.size() < DEPTH) rxq.push_back(in_data);
            else rx_ovf = 1;
        end
        if (cpu_wr && cpu_addr == 2'd2 && m_scr_ena) begin
            if (txq.size() < DEPTH) txq.push_back(cpu_wdata);
            else tx_ovf = 1;
        end
        if (cpu_wr && cpu_addr == 2'd1) begin
            m_kb_ena = cpu_wdata[4];
            m_kb_ie  = cpu_wdata[0];
            if (cpu_wdata[3]) m_kb_of = 0;
        end
        if (cpu_wr && cpu_addr == 2'd3) begin
            m_scr_ena = cpu_wdata[4];
            m_scr_ie  = cpu_wdata[0];
            if (cpu_wdata[3]) m_scr_of = 0;
        end
        if (rx_ovf) m_kb_of = 1;
        if (tx_ovf) m_scr_of = 1;
        m_irq = irq_next;
    endtask

    // One clock with the given inputs; outputs are stable when this returns.
    task automatic cyc(input bit iv, input logic [7:0] id, input bit wr, input bit rd,
                       input logic [1:0] a, input logic [7:0] wd);
        in_valid = iv; in_data = id; cpu_wr = wr; cpu_rd = rd; cpu_addr = a; cpu_wdata = wd;
        @(posedge clk);
        model_edge();
        #1;
        in_valid = 0; cpu_wr = 0; cpu_rd = 0;
    endtask

    task automatic idle();      cyc(0, 8'h00, 0, 0, 2'd0, 8'h00); endtask
    task automatic push(input logic [7:0] d); cyc(1, d, 0, 0, 2'd0, 8'h00); endtask
    task automatic rd(input logic [1:0] a);   cyc(0, 8'h00, 0, 1, a, 8'h00); endtask
    task automatic wr(input logic [1:0] a, input logic [7:0] d); cyc(0, 8'h00, 1, 0, a, d); endtask

    task automatic do_reset();
        rst = 1;
        idle();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h want 00", cpu_rdata); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin errors++;
            $display("FAIL reset_out got v=%b d=%h want v=0 d=00", out_valid, out_data); end
        rd(2'd1);
        checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL reset_kb_csr got %h want 00", cpu_rdata); end
        rd(2'd3);
        checks++; if (cpu_rdata !== 8'h06) begin errors++; $display("FAIL reset_scr_csr got %h want 06", cpu_rdata); end
    endtask

    task automatic test_rx_basic();
        logic [7:0] exp[3] = '{8'h41, 8'h42, 8'h00};
        do_reset();
        wr(2'd1, 8'h10);
        push(8'h41);
        rd(2'd1);
        checks++; if (cpu_rdata !== 8'h14) begin errors++; $display("FAIL rx_dba_set got %h want 14", cpu_rdata); end
        push(8'h42);
        for (int i = 0; i < 3; i++) begin
            rd(2'd0);
            checks++; if (cpu_rdata !== exp[i] || cpu_rdata !== m_rdata) begin errors++;
                $display("FAIL rx_read%0d got %h want %h", i, cpu_rdata, exp[i]); end
        end
        rd(2'd1);
        checks++; if (cpu_rdata !== 8'h10) begin errors++; $display("FAIL rx_dba_clr got %h want 10", cpu_rdata); end
    endtask

    task automatic test_rx_overflow();
        do_reset();
        wr(2'd1, 8'h10);
        for (int i = 1; i <= 5; i++) push(8'(i));
        rd(2'd1);
        checks++; if (cpu_rdata !== 8'h1C) begin errors++; $display("FAIL rx_of_csr got %h want 1C", cpu_rdata); end
        for (int i = 1; i <= 4; i++) begin
            rd(2'd0);
            checks++; if (cpu_rdata !== 8'(i)) begin errors++; $display("FAIL rx_of_read%0d got %h want %h", i, cpu_rdata, 8'(i)); end
        end
        wr(2'd1, 8'h18);
        rd(2'd1);
        checks++; if (cpu_rdata !== 8'h10) begin errors++; $display("FAIL rx_of_clear got %h want 10", cpu_rdata); end
    endtask

    task automatic test_full_simul();
        logic [7:0] exp[5] = '{8'h12, 8'h13, 8'h14, 8'h99, 8'h00};
        do_reset();
        wr(2'd1, 8'h10);
        for (int i = 0; i < 4; i++) push(8'h11 + 8'(i));
        cyc(1, 8'h99, 0, 1, 2'd0, 8'h00);
        checks++; if (cpu_rdata !== 8'h11) begin errors++; $display("FAIL simul_head got %h want 11", cpu_rdata); end
        rd(2'd1);
        checks++; if (cpu_rdata !== 8'h14) begin errors++; $display("FAIL simul_no_of got %h want 14", cpu_rdata); end
        for (int i = 0; i < 5; i++) begin
            rd(2'd0);
            checks++; if (cpu_rdata !== exp[i]) begin errors++; $display("FAIL simul_read%0d got %h want %h", i, cpu_rdata, exp[i]); end
        end
    endtask

    task automatic test_tx();
        do_reset();
        wr(2'd3, 8'h10);
        out_ready = 0;
        for (int i = 0; i < 5; i++) wr(2'd2, 8'hA0 + 8'(i));
        rd(2'd3);
        checks++; if (cpu_rdata !== 8'h1A) begin errors++; $display("FAIL tx_of_csr got %h want 1A", cpu_rdata); end
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 8'hA0 + 8'(i)) begin errors++;
                $display("FAIL tx_drain%0d got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, 8'hA0 + 8'(i)); end
            idle();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL tx_empty got v=%b want 0", out_valid); end
        out_ready = 0;
        // ena cleared with data queued: out_valid drops, data retained
        wr(2'd2, 8'h5A);
        wr(2'd3, 8'h08);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL tx_ena_off got v=%b want 0", out_valid); end
        wr(2'd3, 8'h10);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h5A) begin errors++;
            $display("FAIL tx_retain got v=%b d=%h want v=1 d=5A", out_valid, out_data); end
    endtask

    task automatic test_irq();
        do_reset();
        wr(2'd1, 8'h11);
        push(8'h55);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_latency got %b want 0", irq); end
        idle();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b want 1", irq); end
        rd(2'd0);
        checks++; if (cpu_rdata !== 8'h55 || irq !== 1'b1) begin errors++;
            $display("FAIL irq_pop got d=%h irq=%b want d=55 irq=1", cpu_rdata, irq); end
        idle();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b want 0", irq); end
    endtask

    task automatic test_wrap_reset();
        logic [7:0] d;
        do_reset();
        wr(2'd1, 8'h10);
        push(8'hF0);
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom);
            push(d);
            rd(2'd0);
            checks++; if (cpu_rdata !== m_rdata) begin errors++;
                $display("FAIL wrap%0d got %h want %h", i, cpu_rdata, m_rdata); end
        end
        push(8'h77);
        push(8'h88);
        do_reset();
        rd(2'd1);
        checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL rst_kb_csr got %h want 00", cpu_rdata); end
        rd(2'd0);
        checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL rst_kb_data got %h want 00", cpu_rdata); end
    endtask

    task automatic test_random();
        int op;
        do_reset();
        wr(2'd1, 8'h11);
        wr(2'd3, 8'h11);
        for (int n = 0; n < 600; n++) begin
            out_ready = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 199) == 0);
            op = $urandom_range(0, 9);
            if (op < 4)      cyc($urandom_range(0, 1) == 1, 8'($urandom), 0, 1, 2'($urandom), 8'h00);
            else if (op < 8) cyc($urandom_range(0, 1) == 1, 8'($urandom), 1, 0, 2'd2, 8'($urandom));
            else             cyc($urandom_range(0, 1) == 1, 8'($urandom), 1, 0, 2'($urandom_range(1, 1) + 2 * $urandom_range(0, 1)),
                                 8'($urandom) | 8'h10);
            rst = 0;
            checks++; if (cpu_rdata !== m_rdata) begin errors++; $display("FAIL rand_rdata@%0d got %h want %h", n, cpu_rdata, m_rdata); end
            checks++; if (irq !== m_irq) begin errors++; $display("FAIL rand_irq@%0d got %b want %b", n, irq, m_irq); end
            checks++; if (out_valid !== (m_scr_ena && txq.size() > 0)) begin errors++;
                $display("FAIL rand_out_valid@%0d got %b want %b", n, out_valid, m_scr_ena && txq.size() > 0); end
            if (txq.size() > 0) begin
                checks++; if (out_data !== txq[0]) begin errors++; $display("FAIL rand_out_data@%0d got %h want %h", n, out_data, txq[0]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_rx_basic();
        test_rx_overflow();
        test_full_simul();
        test_tx();
        test_irq();
        test_wrap_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
